// File: rtl/mpu_det_loader_pkg.sv
// Shared MPU constants, loader state encoding and the packed-matrix element offset helper.
package mpu_det_loader_pkg;

  localparam int MPU_N      = 5;
  localparam int MPU_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit offset of element (row,col) on the row-major 5x5 matrix bus.
  function automatic int at(input int row, input int col);
    return MPU_DATA_W * (col + MPU_N * row);
  endfunction

endpackage

// File: rtl/mpu_det_loader_if.sv
// Row-major element stream from the producer into the determinant loader.
interface mpu_det_loader_if #(
  parameter int DATA_W = 8
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/mpu_det_loader.sv
// Packs a size x size element stream onto the 5x5 matrix bus, holds it while the
// determinant unit settles, then captures the determinant with a one-cycle done pulse.
module mpu_det_loader
  import mpu_det_loader_pkg::*;
#(
  parameter int N             = MPU_N,
  parameter int DATA_W        = MPU_DATA_W,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_W-1:0]          size_in,
  mpu_det_loader_if.slave            stream,
  output logic [N*N*DATA_W-1:0]      matrix,
  output logic [DATA_W-1:0]          size,
  input  logic signed [DATA_W-1:0]   det_in,
  output logic                       busy,
  output logic signed [DATA_W-1:0]   result,
  output logic                       done,
  output logic                       error
);

  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] cnt;
  logic [2:0] last;
  logic       size_ok;

  assign last    = size[2:0] - 3'd1;
  assign size_ok = (size_in != '0) && (size_in <= DATA_W'(N));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      matrix          <= '0;
      size            <= '0;
      result          <= '0;
      stream.in_ready <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      row             <= '0;
      col             <= '0;
      cnt             <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (size_ok) begin
              size            <= size_in;
              matrix          <= '0;
              row             <= '0;
              col             <= '0;
              stream.in_ready <= 1'b1;
              busy            <= 1'b1;
              state           <= ST_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (stream.in_valid && stream.in_ready) begin
            // Unrolled so every slice index is a constant.
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                if (r == int'(row) && c == int'(col)) begin
                  matrix[at(r, c) +: DATA_W] <= stream.in_data;
                end
              end
            end
            if (col == last) begin
              col <= '0;
              if (row == last) begin
                stream.in_ready <= 1'b0;
                cnt             <= SETTLE_LOAD;
                state           <= ST_SETTLE;
              end else begin
                row <= row + 3'd1;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
        end

        ST_SETTLE: begin
          if (cnt == '0) begin
            result <= det_in;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
